// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller and scan_sequencer.
// The sequencer drives the decoder select {a,b,c}, en, and the status pulses.
interface scan_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic               a, b, c;
  logic               en;
  logic               busy;
  logic               step;
  logic               wrap;

  modport master (output start, stop, mask, dwell,
                  input  a, b, c, en, busy, step, wrap);
  modport slave  (input  start, stop, mask, dwell,
                  output a, b, c, en, busy, step, wrap);
endinterface

// File: rtl/scan_sequencer.sv
// Masked round-robin channel scanner feeding a 3-to-8 one-hot decoder.
// Define SCAN_BLANK_EN to insert one en=0 BLANK cycle at every channel advance.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input logic   clk,
  input logic   rst_n,
  scan_if.slave sif
);
`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_BLANK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DWELL} state_t;
`endif

  state_t             state, state_n;
  logic [2:0]         idx, idx_n;
  logic [DWELL_W-1:0] cnt, cnt_n, dwell_ld;
  logic               en, en_n, busy, busy_n, step, step_n, wrap, wrap_n;
  logic               to_idle;
  logic [3:0]         first, adv;

  // {found, index}: first set bit of m at or above 'from', wrapping mod 8
  function automatic logic [3:0] next_set(input logic [7:0] m, input logic [2:0] from);
    logic [3:0] r;
    logic [2:0] j;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      j = from + 3'(k);
      if (m[j]) r = {1'b1, j};
    end
    return r;
  endfunction

  assign dwell_ld = (sif.dwell == '0) ? DWELL_W'(1) : sif.dwell;
  assign first    = next_set(sif.mask, 3'd0);
  assign adv      = next_set(sif.mask, idx + 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
      en    <= 1'b0;
      busy  <= 1'b0;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      en    <= en_n;
      busy  <= busy_n;
      step  <= step_n;
      wrap  <= wrap_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    en_n    = en;
    busy_n  = busy;
    step_n  = 1'b0;
    wrap_n  = 1'b0;
    to_idle = 1'b0;
    case (state)
      S_IDLE: begin
        if (sif.start && first[3]) begin
          state_n = S_DWELL;
          idx_n   = first[2:0];
          cnt_n   = dwell_ld;
          en_n    = 1'b1;
          busy_n  = 1'b1;
          step_n  = 1'b1;
        end
      end
      S_DWELL: begin
        if (cnt > DWELL_W'(1)) begin
          cnt_n = cnt - DWELL_W'(1);
        end else if (!adv[3]) begin
          to_idle = 1'b1;
        end else begin
`ifdef SCAN_BLANK_EN
          // select stays on the old channel while the decoder is disabled
          state_n = S_BLANK;
          en_n    = 1'b0;
          cnt_n   = '0;
`else
          idx_n  = adv[2:0];
          cnt_n  = dwell_ld;
          step_n = 1'b1;
          wrap_n = (adv[2:0] <= idx);
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      S_BLANK: begin
        if (!adv[3]) begin
          to_idle = 1'b1;
        end else begin
          state_n = S_DWELL;
          idx_n   = adv[2:0];
          cnt_n   = dwell_ld;
          en_n    = 1'b1;
          step_n  = 1'b1;
          wrap_n  = (adv[2:0] <= idx);
        end
      end
`endif
      default: to_idle = 1'b1;
    endcase
    // stop overrides any transition, including a same-cycle start
    if (sif.stop || to_idle) begin
      state_n = S_IDLE;
      idx_n   = '0;
      cnt_n   = '0;
      en_n    = 1'b0;
      busy_n  = 1'b0;
      step_n  = 1'b0;
      wrap_n  = 1'b0;
    end
  end

  assign sif.a    = idx[2];
  assign sif.b    = idx[1];
  assign sif.c    = idx[0];
  assign sif.en   = en;
  assign sif.busy = busy;
  assign sif.step = step;
  assign sif.wrap = wrap;
endmodule

// File: tb/tb_scan_sequencer.sv
// Directed-vector bench for scan_sequencer; expectations follow SCAN_BLANK_EN when defined.
module tb_scan_sequencer;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  scan_if #(.DWELL_W(DW)) sif ();
  scan_sequencer #(.DWELL_W(DW)) dut (.clk(clk), .rst_n(rst_n), .sif(sif));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // packed as {busy,en,step,wrap,a,b,c}
  task automatic expo(input string tag, input bit busy, input bit en, input bit step,
                      input bit wrap, input logic [2:0] idx);
    chk(tag, 32'({sif.busy, sif.en, sif.step, sif.wrap, sif.a, sif.b, sif.c}),
        32'({busy, en, step, wrap, idx}));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic blank_chk(input string tag, input logic [2:0] idx);
`ifdef SCAN_BLANK_EN
    tick;
    expo(tag, 1'b1, 1'b0, 1'b0, 1'b0, idx);
`endif
  endtask

  task automatic do_stop;
    sif.stop = 1'b1;
    tick;
    sif.stop = 1'b0;
    expo("stop_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  logic [2:0] t2_idx [6] = '{3'd5, 3'd7, 3'd2, 3'd5, 3'd7, 3'd2};
  bit         t2_wrp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    sif.start = 1'b0;
    sif.stop  = 1'b0;
    sif.mask  = 8'h00;
    sif.dwell = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expo("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    tick;
    expo("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // start with empty mask is ignored
    sif.start = 1'b1;
    tick;
    sif.start = 1'b0;
    expo("start_mask0", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // full mask, dwell 2
    sif.mask  = 8'hFF;
    sif.dwell = 8'd2;
    sif.start = 1'b1;
    tick;
    sif.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expo("t1_step", 1'b1, 1'b1, 1'b1, 1'b0, 3'(i));
      tick;
      expo("t1_hold", 1'b1, 1'b1, 1'b0, 1'b0, 3'(i));
      blank_chk("t1_blank", 3'(i));
      tick;
    end
    expo("t1_wrap", 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    do_stop;

    // sparse mask, dwell 1
    sif.mask  = 8'b1010_0100;
    sif.dwell = 8'd1;
    sif.start = 1'b1;
    tick;
    sif.start = 1'b0;
    expo("t2_first", 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
    for (int i = 0; i < 6; i++) begin
      blank_chk("t2_blank", (i == 0) ? 3'd2 : t2_idx[i-1]);
      tick;
      expo("t2_step", 1'b1, 1'b1, 1'b1, t2_wrp[i], t2_idx[i]);
    end
    do_stop;

    // dwell 0 behaves as 1
    sif.mask  = 8'h03;
    sif.dwell = 8'd0;
    sif.start = 1'b1;
    tick;
    sif.start = 1'b0;
    expo("d0_ch0", 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    blank_chk("d0_blank0", 3'd0);
    tick;
    expo("d0_ch1", 1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
    blank_chk("d0_blank1", 3'd1);
    tick;
    expo("d0_wrap", 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    do_stop;

    // single-channel reselect
    sif.mask  = 8'h10;
    sif.dwell = 8'd3;
    sif.start = 1'b1;
    tick;
    sif.start = 1'b0;
    expo("t3_first", 1'b1, 1'b1, 1'b1, 1'b0, 3'd4);
    for (int r = 0; r < 2; r++) begin
      tick;
      expo("t3_hold_a", 1'b1, 1'b1, 1'b0, 1'b0, 3'd4);
      tick;
      expo("t3_hold_b", 1'b1, 1'b1, 1'b0, 1'b0, 3'd4);
      blank_chk("t3_blank", 3'd4);
      tick;
      expo("t3_reselect", 1'b1, 1'b1, 1'b1, 1'b1, 3'd4);
    end
    do_stop;

    // mask cleared mid-dwell: channel completes, then idle
    sif.mask  = 8'h08;
    sif.dwell = 8'd3;
    sif.start = 1'b1;
    tick;
    sif.start = 1'b0;
    expo("t4_ch3", 1'b1, 1'b1, 1'b1, 1'b0, 3'd3);
    sif.mask = 8'h00;
    tick;
    expo("t4_hold_a", 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
    tick;
    expo("t4_hold_b", 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
    tick;
    expo("t4_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // start+stop together, then start held while busy
    sif.mask  = 8'hFF;
    sif.dwell = 8'd2;
    sif.start = 1'b1;
    sif.stop  = 1'b1;
    tick;
    expo("t5_stop_wins", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    sif.stop = 1'b0;
    tick;
    expo("t5_start", 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    tick;
    expo("t5_busy_start", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    blank_chk("t5_blank", 3'd0);
    tick;
    expo("t5_no_restart", 1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
    sif.start = 1'b0;
    do_stop;

    // async reset mid-scan
    sif.start = 1'b1;
    tick;
    sif.start = 1'b0;
    expo("t6_run", 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    expo("t6_async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    tick;
    expo("t6_after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
